restoring_nbit_div: RTL



---
 rtl/restoring_nbit_div.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/restoring_nbit_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : restoring_nbit_div                                            |
// | Purpose  : Sequential restoring divider. Divides a 2*WIDTH-bit dividend  |
// |            by a WIDTH-bit divisor and produces a WIDTH-bit quotient and  |
// |            remainder, one quotient bit per clock. Valid/ready handshake  |
// |            on the operand side and on the result side.                   |
// | Ports    : clk, rst            - clock, synchronous active-high reset    |
// |            in_valid/in_ready   - operand handshake (ready only in IDLE)  |
// |            dividend, divisor   - operands (2*WIDTH and WIDTH bits)       |
// |            out_valid/out_ready - result handshake, result held until     |
// |                                  accepted                                |
// |            quotient, remainder - WIDTH-bit results                       |
// |            div_zero, ovf       - error flags, valid with out_valid       |
// | Config   : DIV_ERR_CHECK_EN - when defined, divide-by-zero and quotient  |
// |            overflow are detected and exit early with zeroed results.     |
// |            When undefined, the flags are tied low and every operation    |
// |            runs all WIDTH steps.                                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module restoring_nbit_div #(
  parameter int WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_zero,
  output logic                 ovf
);

  // Counter counts WIDTH down to 0: WIDTH shift/subtract steps, then one
  // finalize cycle that moves the result into the output registers.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;      // partial remainder (top bit is always 0, so not stored)
  logic [WIDTH-1:0]   quo_q;      // dividend low half shifting out, quotient bits shifting in
  logic [WIDTH-1:0]   dvsr_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;

  logic [WIDTH:0]     w_t;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;

  // One restoring step. The compare is WIDTH+1 bits wide so the bit shifted
  // out of the remainder is not lost; the subtract only needs WIDTH bits
  // because the difference is always below the divisor.
  always_comb begin
    w_t   = {rem_q, quo_q[WIDTH-1]};
    w_ge  = (w_t >= {1'b0, dvsr_q});
    w_sub = w_t[WIDTH-1:0] - dvsr_q;
    rem_d = w_ge ? w_sub : w_t[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], w_ge};
  end

`ifdef DIV_ERR_CHECK_EN
  logic w_dz;
  logic w_ov;
  logic dz_q;
  logic ov_q;

  assign w_dz     = (divisor == '0);
  // Quotient fits in WIDTH bits only when the high half is below the divisor.
  assign w_ov     = (dividend[2*WIDTH-1:WIDTH] >= divisor);
  assign div_zero = dz_q;
  assign ovf      = ov_q;
`else
  assign div_zero = 1'b0;
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ERR_CHECK_EN
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvsr_q     <= divisor;
            rem_q      <= dividend[2*WIDTH-1:WIDTH];
            quo_q      <= dividend[WIDTH-1:0];
            in_ready_q <= 1'b0;
            state_q    <= RUN;
`ifdef DIV_ERR_CHECK_EN
            dz_q       <= w_dz;
            ov_q       <= w_ov && !w_dz;
            // Errors skip straight to the finalize cycle.
            cnt_q      <= (w_dz || w_ov) ? '0 : CNT_W'(WIDTH);
`else
            cnt_q      <= CNT_W'(WIDTH);
`endif
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            quotient_q  <= quo_q;
            remainder_q <= rem_q;
`ifdef DIV_ERR_CHECK_EN
            if (dz_q || ov_q) begin
              quotient_q  <= '0;
              remainder_q <= '0;
            end
`endif
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
`default_nettype wire
